// File: rtl/mux81_scan_ctrl_if.sv
// rtl/mux81_scan_ctrl_if.sv - mux drive/capture lines and result stream of the 8:1 mux scanner
interface mux81_scan_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             mux_csn;
   logic [2:0]       mux_sel;
   logic [WIDTH-1:0] mux_y;
   logic [WIDTH-1:0] out_data;
   logic [2:0]       out_ch;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output mux_csn,
      output mux_sel,
      input  mux_y,
      output out_data,
      output out_ch,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  mux_csn,
      input  mux_sel,
      output mux_y,
      input  out_data,
      input  out_ch,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/mux81_scan_ctrl.sv
// rtl/mux81_scan_ctrl.sv - round-robin 8:1 mux scanner with fixed dwell and valid/ready result port
module mux81_scan_ctrl #(
   parameter int WIDTH = 8,
   parameter int DWELL = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [7:0]          ch_mask,
   output logic                busy,
   mux81_scan_ctrl_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD
   } state_t;

   state_t           state;
   logic [7:0]       cnt;
   logic [2:0]       last;
   logic [2:0]       pick;
   logic             csn_q;
   logic [2:0]       sel_q;
   logic [WIDTH-1:0] data_q;
   logic [2:0]       ch_q;
   logic             valid_q;
   logic             busy_q;
   logic             can_pick;

   assign can_pick      = en && (ch_mask != 8'h00);
   assign bus.mux_csn   = csn_q;
   assign bus.mux_sel   = sel_q;
   assign bus.out_data  = data_q;
   assign bus.out_ch    = ch_q;
   assign bus.out_valid = valid_q;
   assign busy          = busy_q;

   // Walk downward so the nearest enabled channel after last wins; falls back to last itself.
   always_comb begin
      pick = last;
      for (int i = 7; i >= 1; i--) begin
         if (ch_mask[3'(last + 3'(i))]) pick = 3'(last + 3'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         last    <= 3'd7;
         csn_q   <= 1'b1;
         sel_q   <= 3'd0;
         data_q  <= '0;
         ch_q    <= 3'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               csn_q <= 1'b1;
               if (can_pick) begin
                  sel_q  <= pick;
                  last   <= pick;
                  csn_q  <= 1'b0;
                  cnt    <= 8'(DWELL - 1);
                  busy_q <= 1'b1;
                  state  <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  data_q  <= bus.mux_y;
                  ch_q    <= sel_q;
                  valid_q <= 1'b1;
                  csn_q   <= 1'b1;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  // Chain straight into the next channel so back-to-back results have no idle gap.
                  if (can_pick) begin
                     sel_q <= pick;
                     last  <= pick;
                     csn_q <= 1'b0;
                     cnt   <= 8'(DWELL - 1);
                     state <= SETTLE;
                  end else begin
                     busy_q <= 1'b0;
                     state  <= IDLE;
                  end
               end
            end
            default: begin
               csn_q   <= 1'b1;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux81_scan_ctrl.sv
// tb/tb_mux81_scan_ctrl.sv - directed self-checking bench for mux81_scan_ctrl
module tb_mux81_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] ch_mask;
   logic       busy;
   int         total = 0;
   int         passed = 0;
   int         failed = 0;
   int         viol = 0;

   mux81_scan_ctrl_if #(.WIDTH(8)) bus ();

   mux81_scan_ctrl #(.WIDTH(8), .DWELL(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .ch_mask (ch_mask),
      .busy    (busy),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Mux model: Y = 8'h10 + A while selected, 0 otherwise.
   assign bus.mux_y = bus.mux_csn ? 8'h00 : 8'(8'h10 + {5'd0, bus.mux_sel});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (!bus.mux_csn && !ch_mask[bus.mux_sel]) viol++;
   endtask

   task automatic get_result(input string tag, output logic [2:0] ch, output logic [7:0] d);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.out_valid && n < 40);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      ch = bus.out_ch;
      d  = bus.out_data;
   endtask

   initial begin
      logic [2:0] ch;
      logic [7:0] d;
      int         n;
      int         low;
      int         bad;
      logic [2:0] seq2 [5];
      seq2[0] = 3'd2; seq2[1] = 3'd5; seq2[2] = 3'd7; seq2[3] = 3'd2; seq2[4] = 3'd5;

      rst_n = 1'b0;
      en = 1'b0;
      ch_mask = 8'h00;
      bus.out_ready = 1'b1;
      tick();
      check("rst_csn",   32'(bus.mux_csn),   32'd1);
      check("rst_sel",   32'(bus.mux_sel),   32'd0);
      check("rst_data",  32'(bus.out_data),  32'd0);
      check("rst_ch",    32'(bus.out_ch),    32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy",  32'(busy),          32'd0);
      rst_n = 1'b1;
      tick();

      // 1: full mask, free-running
      ch_mask = 8'hFF;
      en = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.out_valid && n < 40);
      check("t1_latency", 32'(n), 32'd5);
      for (int k = 0; k < 9; k++) begin
         check("t1_ch",   32'(bus.out_ch),   32'(k % 8));
         check("t1_data", 32'(bus.out_data), 32'(8'h10 + k % 8));
         if (k == 8) break;
         n = 0;
         low = 0;
         do begin
            tick();
            n++;
            if (!bus.mux_csn) low++;
         end while (!bus.out_valid && n < 40);
         check("t1_period", 32'(n),   32'd5);
         check("t1_csnlow", 32'(low), 32'd4);
      end
      en = 1'b0;
      tick();
      check("t1_idle_valid", 32'(bus.out_valid), 32'd0);
      check("t1_idle_busy",  32'(busy),          32'd0);
      check("t1_idle_csn",   32'(bus.mux_csn),   32'd1);

      // 2: sparse mask
      ch_mask = 8'b1010_0100;
      en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         get_result("t2", ch, d);
         check("t2_ch",   32'(ch), 32'(seq2[k]));
         check("t2_data", 32'(d),  32'(8'h10 + {5'd0, seq2[k]}));
      end
      en = 1'b0;
      tick();
      check("t2_masked_sel", 32'(viol), 32'd0);

      // 3: backpressure on the first result after reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      ch_mask = 8'hFF;
      bus.out_ready = 1'b0;
      en = 1'b1;
      get_result("t3", ch, d);
      check("t3_ch",   32'(ch), 32'd0);
      check("t3_data", 32'(d),  32'h10);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10 || bus.out_ch !== 3'd0 || bus.mux_csn !== 1'b1) bad++;
      end
      check("t3_stall_stable", 32'(bad), 32'd0);
      bus.out_ready = 1'b1;
      tick();
      check("t3_next_csn",   32'(bus.mux_csn),   32'd0);
      check("t3_next_sel",   32'(bus.mux_sel),   32'd1);
      check("t3_next_valid", 32'(bus.out_valid), 32'd0);
      get_result("t3b", ch, d);
      check("t3_ch1",   32'(ch), 32'd1);
      check("t3_data1", 32'(d),  32'h11);

      // 4: en dropped while ch3 settles
      get_result("t4a", ch, d);
      check("t4_ch2", 32'(ch), 32'd2);
      tick();
      check("t4_settle_sel", 32'(bus.mux_sel), 32'd3);
      check("t4_settle_csn", 32'(bus.mux_csn), 32'd0);
      en = 1'b0;
      get_result("t4b", ch, d);
      check("t4_ch3",   32'(ch), 32'd3);
      check("t4_data3", 32'(d),  32'h13);
      tick();
      check("t4_busy",  32'(busy),          32'd0);
      check("t4_csn",   32'(bus.mux_csn),   32'd1);
      check("t4_valid", 32'(bus.out_valid), 32'd0);

      // 5: empty mask keeps it idle, then a single channel repeats
      ch_mask = 8'h00;
      en = 1'b1;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (bus.mux_csn !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("t5_idle", 32'(bad), 32'd0);
      ch_mask = 8'h08;
      for (int k = 0; k < 3; k++) begin
         get_result("t5", ch, d);
         check("t5_ch",   32'(ch), 32'd3);
         check("t5_data", 32'(d),  32'h13);
      end
      en = 1'b0;
      tick();

      // 6: asynchronous reset in the middle of SETTLE
      ch_mask = 8'hFF;
      en = 1'b1;
      tick();
      tick();
      check("t6_in_settle", 32'(bus.mux_csn), 32'd0);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_async_csn",   32'(bus.mux_csn),   32'd1);
      check("t6_async_valid", 32'(bus.out_valid), 32'd0);
      check("t6_async_busy",  32'(busy),          32'd0);
      #2;
      rst_n = 1'b1;
      get_result("t6", ch, d);
      check("t6_ch",   32'(ch), 32'd0);
      check("t6_data", 32'(d),  32'h10);
      check("final_masked_sel", 32'(viol), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
